// File: rtl/raster_sequencer.sv
// raster_sequencer: fetches triangles from vertex BRAM, clips their bounding boxes and streams candidate pixels.
// Define BACKFACE_CULL_EN to reject triangles whose signed area is not positive.
module raster_sequencer #(
    parameter int SCREEN_W      = 800,
    parameter int SCREEN_H      = 600,
    parameter int COORD_W       = 11,
    parameter int ADDR_W        = 14,
    parameter int VERTEX_STRIDE = 4,
    parameter int BRAM_LAT      = 1,
    parameter int COLOR_W       = 8,
    parameter int CLEAR_COLOR   = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [31:0]               vertex_count,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic signed [COORD_W-1:0] mem_data,
    output logic signed [COORD_W-1:0] pix_x,
    output logic signed [COORD_W-1:0] pix_y,
    output logic signed [COORD_W-1:0] tri_v1x,
    output logic signed [COORD_W-1:0] tri_v1y,
    output logic signed [COORD_W-1:0] tri_v2x,
    output logic signed [COORD_W-1:0] tri_v2y,
    output logic signed [COORD_W-1:0] tri_v3x,
    output logic signed [COORD_W-1:0] tri_v3y,
    output logic [COLOR_W-1:0]        pix_color,
    output logic                      pix_clear,
    output logic                      pix_valid,
    input  logic                      pix_ready,
    output logic signed [COORD_W-1:0] bb_width,
    output logic signed [COORD_W-1:0] bb_height,
    output logic                      busy,
    output logic                      frame_end
);
    localparam int TRI_WORDS = 3 * VERTEX_STRIDE;
    localparam int FC_W = $clog2(TRI_WORDS + BRAM_LAT + 1);
    localparam int AW = 2 * COORD_W + 1;
    localparam logic signed [COORD_W-1:0] ZERO = '0;
    localparam logic signed [COORD_W-1:0] XMAX = COORD_W'(SCREEN_W - 1);
    localparam logic signed [COORD_W-1:0] YMAX = COORD_W'(SCREEN_H - 1);
    localparam logic signed [COORD_W-1:0] HALF_X = COORD_W'(SCREEN_W / 2);
    localparam logic signed [COORD_W-1:0] HALF_Y = COORD_W'(SCREEN_H / 2);
`ifdef BACKFACE_CULL_EN
    localparam int BB_CYC = 3;
`else
    localparam int BB_CYC = 2;
`endif

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_TRAVERSE, S_NEXT, S_FETCH, S_BBOX, S_CLIP, S_DONE} state_t;

    state_t state_q, state_d;
    logic [31:0] tri_left_q, tri_left_d;
    logic [ADDR_W-1:0] base_q, base_d, mem_addr_q, mem_addr_d;
    logic [FC_W-1:0] fcnt_q, fcnt_d, comp_q, comp_d;
    logic [1:0] vidx_q, vidx_d, bcnt_q, bcnt_d;
    logic signed [COORD_W-1:0] vx_q [3], vx_d [3], vy_q [3], vy_d [3];
    logic signed [COORD_W-1:0] tlx_q, tlx_d, tly_q, tly_d, brx_q, brx_d, bry_q, bry_d;
    logic signed [COORD_W-1:0] px_q, px_d, py_q, py_d, bbw_q, bbw_d, bbh_q, bbh_d;
    logic [COLOR_W-1:0] color_q, color_d, pix_color_q, pix_color_d;
    logic pix_clear_q, pix_clear_d, tri_seen_q, tri_seen_d;
    logic off_screen, reject;
    logic signed [COORD_W-1:0] clx, cly, crx, cry;

    function automatic logic signed [COORD_W-1:0] smin(input logic signed [COORD_W-1:0] a, input logic signed [COORD_W-1:0] b);
        return a < b ? a : b;
    endfunction

    function automatic logic signed [COORD_W-1:0] smax(input logic signed [COORD_W-1:0] a, input logic signed [COORD_W-1:0] b);
        return a > b ? a : b;
    endfunction

    assign off_screen = brx_q < ZERO || bry_q < ZERO || tlx_q > XMAX || tly_q > YMAX;
    assign clx = smax(tlx_q, ZERO);
    assign cly = smax(tly_q, ZERO);
    assign crx = smin(brx_q, XMAX);
    assign cry = smin(bry_q, YMAX);

`ifdef BACKFACE_CULL_EN
    localparam logic signed [AW-1:0] AZERO = '0;
    logic signed [AW-1:0] area_q, area_d, e1x, e1y, e2x, e2y;
    assign e1x = AW'(vx_q[1]) - AW'(vx_q[0]);
    assign e1y = AW'(vy_q[1]) - AW'(vy_q[0]);
    assign e2x = AW'(vx_q[2]) - AW'(vx_q[0]);
    assign e2y = AW'(vy_q[2]) - AW'(vy_q[0]);
    assign area_d = state_q == S_BBOX && bcnt_q == 2'd2 ? e1x * e2y - e2x * e1y : area_q;
    assign reject = off_screen || area_q <= AZERO;
    always_ff @(posedge clk or posedge rst)
        if (rst) area_q <= '0;
        else area_q <= area_d;
`else
    assign reject = off_screen;
`endif

    always_comb begin
        state_d = state_q;
        tri_left_d = tri_left_q;
        base_d = base_q;
        mem_addr_d = mem_addr_q;
        fcnt_d = fcnt_q;
        comp_d = comp_q;
        vidx_d = vidx_q;
        bcnt_d = bcnt_q;
        vx_d = vx_q;
        vy_d = vy_q;
        tlx_d = tlx_q;
        tly_d = tly_q;
        brx_d = brx_q;
        bry_d = bry_q;
        px_d = px_q;
        py_d = py_q;
        bbw_d = bbw_q;
        bbh_d = bbh_q;
        color_d = color_q;
        pix_color_d = pix_color_q;
        pix_clear_d = pix_clear_q;
        tri_seen_d = tri_seen_q;
        case (state_q)
            S_IDLE: if (start) begin
                tri_left_d = vertex_count / 32'(TRI_WORDS);
                base_d = '0;
                mem_addr_d = '0;
                color_d = COLOR_W'(1);
                tri_seen_d = 1'b0;
                state_d = S_CLEAR;
            end
            S_CLEAR: begin
                tlx_d = ZERO;
                tly_d = ZERO;
                brx_d = XMAX;
                bry_d = YMAX;
                px_d = ZERO;
                py_d = ZERO;
                bbw_d = XMAX;
                bbh_d = YMAX;
                pix_clear_d = 1'b1;
                pix_color_d = COLOR_W'(CLEAR_COLOR);
                state_d = S_TRAVERSE;
            end
            S_TRAVERSE: if (pix_ready) begin
                if (px_q != brx_q) px_d = px_q + COORD_W'(1);
                else if (py_q != bry_q) begin
                    px_d = tlx_q;
                    py_d = py_q + COORD_W'(1);
                end else begin
                    pix_clear_d = 1'b0;
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                // the clear pass does not consume a colour
                color_d = tri_seen_q ? color_q + COLOR_W'(1) : color_q;
                if (tri_left_q != 0) begin
                    tri_left_d = tri_left_q - 32'd1;
                    mem_addr_d = base_q;
                    base_d = base_q + ADDR_W'(TRI_WORDS);
                    fcnt_d = '0;
                    comp_d = '0;
                    vidx_d = '0;
                    tri_seen_d = 1'b1;
                    state_d = S_FETCH;
                end else state_d = S_DONE;
            end
            S_FETCH: begin
                fcnt_d = fcnt_q + FC_W'(1);
                if (fcnt_q < FC_W'(TRI_WORDS - 1)) mem_addr_d = mem_addr_q + ADDR_W'(1);
                if (fcnt_q >= FC_W'(BRAM_LAT)) begin
                    if (comp_q == '0) vx_d[vidx_q] = mem_data + HALF_X;
                    if (comp_q == FC_W'(1)) vy_d[vidx_q] = mem_data + HALF_Y;
                    comp_d = comp_q == FC_W'(VERTEX_STRIDE - 1) ? '0 : comp_q + FC_W'(1);
                    vidx_d = comp_q == FC_W'(VERTEX_STRIDE - 1) ? vidx_q + 2'd1 : vidx_q;
                end
                if (fcnt_q == FC_W'(TRI_WORDS - 1 + BRAM_LAT)) begin
                    bcnt_d = '0;
                    state_d = S_BBOX;
                end
            end
            S_BBOX: begin
                bcnt_d = bcnt_q + 2'd1;
                if (bcnt_q == 2'd0) begin
                    tlx_d = smin(vx_q[0], vx_q[1]);
                    tly_d = smin(vy_q[0], vy_q[1]);
                    brx_d = smax(vx_q[0], vx_q[1]);
                    bry_d = smax(vy_q[0], vy_q[1]);
                end else if (bcnt_q == 2'd1) begin
                    tlx_d = smin(tlx_q, vx_q[2]);
                    tly_d = smin(tly_q, vy_q[2]);
                    brx_d = smax(brx_q, vx_q[2]);
                    bry_d = smax(bry_q, vy_q[2]);
                end
                if (bcnt_q == 2'(BB_CYC - 1)) state_d = S_CLIP;
            end
            S_CLIP: if (reject) state_d = S_NEXT;
            else begin
                tlx_d = clx;
                tly_d = cly;
                brx_d = crx;
                bry_d = cry;
                px_d = clx;
                py_d = cly;
                bbw_d = crx - clx;
                bbh_d = cry - cly;
                pix_color_d = color_q;
                state_d = S_TRAVERSE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= S_IDLE;
            tri_left_q <= '0;
            base_q <= '0;
            mem_addr_q <= '0;
            fcnt_q <= '0;
            comp_q <= '0;
            vidx_q <= '0;
            bcnt_q <= '0;
            vx_q <= '{default: '0};
            vy_q <= '{default: '0};
            tlx_q <= '0;
            tly_q <= '0;
            brx_q <= '0;
            bry_q <= '0;
            px_q <= '0;
            py_q <= '0;
            bbw_q <= '0;
            bbh_q <= '0;
            color_q <= COLOR_W'(1);
            pix_color_q <= '0;
            pix_clear_q <= 1'b0;
            tri_seen_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tri_left_q <= tri_left_d;
            base_q <= base_d;
            mem_addr_q <= mem_addr_d;
            fcnt_q <= fcnt_d;
            comp_q <= comp_d;
            vidx_q <= vidx_d;
            bcnt_q <= bcnt_d;
            vx_q <= vx_d;
            vy_q <= vy_d;
            tlx_q <= tlx_d;
            tly_q <= tly_d;
            brx_q <= brx_d;
            bry_q <= bry_d;
            px_q <= px_d;
            py_q <= py_d;
            bbw_q <= bbw_d;
            bbh_q <= bbh_d;
            color_q <= color_d;
            pix_color_q <= pix_color_d;
            pix_clear_q <= pix_clear_d;
            tri_seen_q <= tri_seen_d;
        end

    assign mem_addr = mem_addr_q;
    assign pix_x = px_q;
    assign pix_y = py_q;
    assign tri_v1x = vx_q[0];
    assign tri_v1y = vy_q[0];
    assign tri_v2x = vx_q[1];
    assign tri_v2y = vy_q[1];
    assign tri_v3x = vx_q[2];
    assign tri_v3y = vy_q[2];
    assign pix_color = pix_color_q;
    assign pix_clear = pix_clear_q;
    assign bb_width = bbw_q;
    assign bb_height = bbh_q;
    assign pix_valid = state_q == S_TRAVERSE;
    assign busy = state_q != S_IDLE && state_q != S_DONE;
    assign frame_end = state_q == S_DONE;
endmodule

// File: tb/tb_raster_sequencer.sv
// tb_raster_sequencer: 8x4 screen, randomized frames and ready patterns checked against a per-frame pixel list model.
module tb_raster_sequencer;
    localparam int W = 8;
    localparam int H = 4;
    localparam int CW = 11;

    logic clk = 0, rst = 1, start = 0, pix_ready = 0;
    logic [31:0] vertex_count = 0;
    logic [13:0] mem_addr;
    logic signed [CW-1:0] mem_data;
    logic signed [CW-1:0] pix_x, pix_y, tri_v1x, tri_v1y, tri_v2x, tri_v2y, tri_v3x, tri_v3y, bb_width, bb_height;
    logic [7:0] pix_color;
    logic pix_clear, pix_valid, busy, frame_end;

    raster_sequencer #(.SCREEN_W(W), .SCREEN_H(H)) dut (
        .clk(clk), .rst(rst), .start(start), .vertex_count(vertex_count),
        .mem_addr(mem_addr), .mem_data(mem_data),
        .pix_x(pix_x), .pix_y(pix_y),
        .tri_v1x(tri_v1x), .tri_v1y(tri_v1y), .tri_v2x(tri_v2x), .tri_v2y(tri_v2y),
        .tri_v3x(tri_v3x), .tri_v3y(tri_v3y),
        .pix_color(pix_color), .pix_clear(pix_clear), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .bb_width(bb_width), .bb_height(bb_height), .busy(busy), .frame_end(frame_end)
    );

    always #5 clk = ~clk;

    logic signed [CW-1:0] mem [256];
    always @(posedge clk) mem_data <= mem[mem_addr[7:0]];

    typedef struct {
        int x, y, col, clr;
        int v1x, v1y, v2x, v2y, v3x, v3y;
        int bw, bh;
    } pix_t;

    pix_t exp_q [$];
    int checks = 0, errors = 0;
    int hs_frame = 0, fe_cnt = 0, nexp = 0;
    int got_first = 0, first_col = 0, first_bbw = 0, first_bbh = 0;
    int rmode = 0, pat = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int wrap(input int v);
        logic signed [CW-1:0] t;
        t = CW'(v);
        return int'(t);
    endfunction

    task automatic set_vtx(input int w, input int x, input int y);
        mem[w] = CW'(x);
        mem[w+1] = CW'(y);
        mem[w+2] = CW'($urandom);
        mem[w+3] = CW'($urandom);
    endtask

    // Expected pixel stream of one frame: clear pass, then each surviving triangle's clipped box.
    task automatic build_frame(input int vc);
        int vx [3], vy [3];
        int ntri, col, mnx, mny, mxx, mxy, area;
        pix_t p;
        exp_q.delete();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                p = '{x, y, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
                exp_q.push_back(p);
            end
        ntri = vc / 12;
        col = 1;
        for (int t = 0; t < ntri; t++) begin
            for (int v = 0; v < 3; v++) begin
                vx[v] = wrap(int'(mem[t*12+v*4]) + W/2);
                vy[v] = wrap(int'(mem[t*12+v*4+1]) + H/2);
            end
            mnx = vx[0]; mxx = vx[0]; mny = vy[0]; mxy = vy[0];
            for (int v = 1; v < 3; v++) begin
                if (vx[v] < mnx) mnx = vx[v];
                if (vx[v] > mxx) mxx = vx[v];
                if (vy[v] < mny) mny = vy[v];
                if (vy[v] > mxy) mxy = vy[v];
            end
            area = (vx[1]-vx[0])*(vy[2]-vy[0]) - (vx[2]-vx[0])*(vy[1]-vy[0]);
`ifdef BACKFACE_CULL_EN
            if (!(mxx < 0 || mxy < 0 || mnx > W-1 || mny > H-1 || area <= 0)) begin
`else
            if (!(mxx < 0 || mxy < 0 || mnx > W-1 || mny > H-1) || area == 1 << 30) begin
`endif
                if (mnx < 0) mnx = 0;
                if (mny < 0) mny = 0;
                if (mxx > W-1) mxx = W-1;
                if (mxy > H-1) mxy = H-1;
                for (int y = mny; y <= mxy; y++)
                    for (int x = mnx; x <= mxx; x++) begin
                        p = '{x, y, col, 0, vx[0], vy[0], vx[1], vy[1], vx[2], vy[2], mxx-mnx, mxy-mny};
                        exp_q.push_back(p);
                    end
            end
            col = (col + 1) % 256;
        end
        nexp = exp_q.size();
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (rmode == 0) pix_ready = 1;
        else if (rmode == 1) begin
            pix_ready = (pat % 4 == 0) || (pat % 4 == 3);
            pat++;
        end else pix_ready = 1'($urandom_range(1));
    end

    always @(negedge clk) if (!rst) begin
        if (pix_valid) begin
            if (exp_q.size() == 0) chk("pix_valid_unexpected", int'(pix_valid), 0);
            else begin
                chk("pix_x", int'(pix_x), exp_q[0].x);
                chk("pix_y", int'(pix_y), exp_q[0].y);
                chk("pix_clear", int'(pix_clear), exp_q[0].clr);
                chk("pix_color", int'(pix_color), exp_q[0].col);
                chk("busy_traverse", int'(busy), 1);
                if (exp_q[0].clr == 0) begin
                    chk("tri_v1x", int'(tri_v1x), exp_q[0].v1x);
                    chk("tri_v1y", int'(tri_v1y), exp_q[0].v1y);
                    chk("tri_v2x", int'(tri_v2x), exp_q[0].v2x);
                    chk("tri_v2y", int'(tri_v2y), exp_q[0].v2y);
                    chk("tri_v3x", int'(tri_v3x), exp_q[0].v3x);
                    chk("tri_v3y", int'(tri_v3y), exp_q[0].v3y);
                    chk("bb_width", int'(bb_width), exp_q[0].bw);
                    chk("bb_height", int'(bb_height), exp_q[0].bh);
                end
                if (pix_ready) begin
                    if (exp_q[0].clr == 0 && got_first == 0) begin
                        got_first = 1;
                        first_col = int'(pix_color);
                        first_bbw = int'(bb_width);
                        first_bbh = int'(bb_height);
                    end
                    void'(exp_q.pop_front());
                    hs_frame++;
                end
            end
        end
        if (frame_end) begin
            fe_cnt++;
            chk("busy_at_frame_end", int'(busy), 0);
            chk("pixels_left_at_frame_end", exp_q.size(), 0);
        end
    end

    task automatic start_frame(input int vc);
        build_frame(vc);
        hs_frame = 0;
        got_first = 0;
        @(posedge clk);
        #1;
        vertex_count = vc;
        start = 1;
        repeat (3) @(posedge clk);
        #1;
        start = 0;
    endtask

    task automatic run_frame(input int vc);
        int fe0;
        fe0 = fe_cnt;
        start_frame(vc);
        for (int n = 0; n < 5000 && fe_cnt == fe0; n++) @(posedge clk);
        repeat (3) @(posedge clk);
        chk("frame_end_pulses", fe_cnt - fe0, 1);
        chk("handshakes_vs_model", hs_frame, nexp);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pix_valid", int'(pix_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_frame_end", int'(frame_end), 0);
        chk("rst_mem_addr", int'(mem_addr), 0);
        chk("rst_pix_x", int'(pix_x), 0);
        chk("rst_pix_color", int'(pix_color), 0);
        chk("rst_pix_clear", int'(pix_clear), 0);
        chk("rst_bb_width", int'(bb_width), 0);
        rst = 0;

        rmode = 0;
        run_frame(0);
        chk("clear_only_pixels", hs_frame, 32);

        set_vtx(0, -4, -2); set_vtx(4, 0, 1); set_vtx(8, 2, -2);
`ifndef BACKFACE_CULL_EN
        run_frame(12);
        chk("model_tri_size", nexp, 60);
        chk("tri_bb_width", first_bbw, 6);
        chk("tri_bb_height", first_bbh, 3);
        chk("tri_color", first_col, 1);

        rmode = 1;
        run_frame(12);
        chk("stalled_handshakes", hs_frame, 60);

        rmode = 0;
        set_vtx(0, 16, 0); set_vtx(4, 18, 1); set_vtx(8, 17, -1);
        set_vtx(12, -4, -2); set_vtx(16, 0, 1); set_vtx(20, 2, -2);
        run_frame(24);
        chk("offscreen_then_valid_color", first_col, 2);
        chk("offscreen_then_valid_pixels", hs_frame, 60);

        set_vtx(0, -4, -2); set_vtx(4, 0, 1); set_vtx(8, 2, -2);
        mem[12] = 11'sd1;
        rmode = 2;
        run_frame(13);
        chk("remainder_ignored_pixels", hs_frame, 60);
`else
        run_frame(12);
        chk("clockwise_culled", hs_frame, 32);
        set_vtx(4, 2, -2); set_vtx(8, 0, 1);
        rmode = 1;
        run_frame(12);
        chk("ccw_traversed", hs_frame, 60);
        chk("ccw_color", first_col, 1);
`endif

        rmode = 2;
        for (int f = 0; f < 6; f++) begin
            int ntri;
            ntri = $urandom_range(4);
            for (int t = 0; t < ntri; t++)
                for (int v = 0; v < 3; v++)
                    set_vtx(t*12 + v*4, $urandom_range(24) - 12, $urandom_range(12) - 6);
            run_frame(ntri * 12 + $urandom_range(11));
        end

        set_vtx(0, -4, -2); set_vtx(4, 0, 1); set_vtx(8, 2, -2);
        set_vtx(4, 2, -2); set_vtx(8, 0, 1);
        rmode = 0;
        start_frame(12);
        for (int n = 0; n < 2000 && hs_frame < 40; n++) @(posedge clk);
        chk("reached_triangle_traverse", int'(hs_frame >= 40), 1);
        @(posedge clk);
        #2;
        rst = 1;
        #1;
        chk("midrst_pix_valid", int'(pix_valid), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_pix_x", int'(pix_x), 0);
        chk("midrst_pix_color", int'(pix_color), 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        run_frame(0);
        chk("after_rst_clear_pixels", hs_frame, 32);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/raster_sequencer.md
Name: raster_sequencer

Overview:
- Parametrised triangle-traversal sequencer: reads packed vertex words from a vertex BRAM, computes each triangle's clipped bounding box, and streams candidate pixels plus triangle vertices to a downstream edge-function rasterizer core over valid/ready.
- Sits between the vertex buffer and the rasterizer core; the core's inside flag gates framebuffer writes.
- Each frame opens with a full-screen clear pass.
- Generalises screen size, vertex stride, BRAM latency, colour width and origin offset; adds off-screen rejection and optional back-face culling.

Parameters:
SCREEN_W, 800, horizontal resolution in pixels
SCREEN_H, 600, vertical resolution in pixels
COORD_W, 11, signed coordinate width for vertices and pixels
ADDR_W, 14, vertex BRAM address width
VERTEX_STRIDE, 4, words per vertex; word 0 = x, word 1 = y, rest ignored (min 2)
BRAM_LAT, 1, cycles from mem_addr change to valid mem_data (1..3)
COLOR_W, 8, colour index width
CLEAR_COLOR, 0, colour emitted during the clear pass

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
start  in  1  begin a frame; sampled in IDLE only
vertex_count  in  32  number of words in the vertex buffer
mem_addr  out  ADDR_W  vertex BRAM read address
mem_data  in  COORD_W  vertex word, signed, origin at screen centre
pix_x, pix_y  out  COORD_W each  candidate pixel
tri_v1x..tri_v3y  out  COORD_W each  six screen-space vertex coordinates, stable during a traversal
pix_color  out  COLOR_W  colour for the current pixel stream
pix_clear  out  1  high during the clear pass; downstream treats every pixel as inside
pix_valid  out  1  candidate pixel valid
pix_ready  in  1  downstream accepts
bb_width, bb_height  out  COORD_W each  BR minus TL of the current box
busy  out  1  high from the start acceptance until frame_end
frame_end  out  1  one-cycle pulse when the frame completes

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; colour counter 1.
- Screen transform: each x word gets +SCREEN_W/2 and each y word gets +SCREEN_H/2, computed at COORD_W bits signed with wrap.
- Triangle count: floor(vertex_count / (3*VERTEX_STRIDE)). Remainder words are ignored. Count 0 means the frame ends after the clear pass.
- FSM: IDLE -> CLEAR -> TRAVERSE -> (NEXT -> FETCH -> BBOX -> CLIP -> TRAVERSE)* -> DONE -> IDLE.
- IDLE: on start, latch the triangle count, set mem_addr=0, colour=1, busy=1. A start while busy is ignored.
- CLEAR: box (0,0)-(SCREEN_W-1, SCREEN_H-1); pix_clear=1; pix_color=CLEAR_COLOR.
- FETCH:
  - Issue addresses base .. base+3*VERTEX_STRIDE-1, one per cycle.
  - Capture x and y words BRAM_LAT cycles after the matching address.
  - base advances by 3*VERTEX_STRIDE per triangle.
- BBOX (2 cycles): min and max of the three x and three y values.
- CLIP (1 cycle):
  - If BR_x<0, BR_y<0, TL_x>SCREEN_W-1 or TL_y>SCREEN_H-1, reject the triangle and go to NEXT. No pixels are emitted; the colour still advances.
  - Otherwise clamp TL and BR to [0, dim-1].
  - Zero-width or zero-height boxes are traversed; they are not skipped.
- TRAVERSE:
  - Raster order, inclusive of both box corners.
  - pix_valid=1 continuously. The pixel advances only on pix_valid&&pix_ready.
  - pix_x/pix_y are held stable while stalled.
  - The last pixel's handshake goes to NEXT and clears pix_clear.
- NEXT: colour+1 (wraps modulo 2^COLOR_W). Go to FETCH if triangles remain, else DONE.
- DONE: frame_end=1 for exactly one cycle, busy=0, then IDLE.
- tri_* and pix_color change only outside TRAVERSE.
- pix_valid is 0 in every state except TRAVERSE.
- rst mid-frame: immediate return to reset values; no partial handshake is completed.

Optional Feature:
BACKFACE_CULL_EN:
- Defined: BBOX additionally computes signed area2 = (v2x-v1x)*(v3y-v1y) - (v3x-v1x)*(v2y-v1y) at 2*COORD_W+1 bits. area2<=0 rejects the triangle like an off-screen reject (colour still advances). Adds one BBOX cycle.
- Undefined: no area computation; all on-screen triangles are traversed regardless of winding.

Test Plan:
- SCREEN_W=8, SCREEN_H=4, vertex_count=0, pix_ready=1 -> 32 pixels with pix_clear=1, colour 0, in raster order (0,0)..(7,3); then one frame_end pulse.
- Triangle raw (-4,-2),(0,1),(2,-2) on 8x4 screen -> after clear, box (0,0)-(6,3), 28 pixels, pix_color=1, bb_width=6, bb_height=3.
- Same triangle with pix_ready toggling 1,0,0,1 -> no pixel is dropped or duplicated; coordinates held during stalls; still 28 handshakes.
- Triangle fully at x>=20 followed by a valid triangle -> first emits no pixels; second uses colour 2.
- vertex_count=13, VERTEX_STRIDE=4 -> one triangle processed and the remainder ignored; rst asserted mid-TRAVERSE -> pix_valid=0 and busy=0 immediately.
- BACKFACE_CULL_EN with a clockwise triangle -> no pixels emitted; with counter-clockwise winding the triangle is traversed normally.
